// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
// The rotating-priority search lives here so rr_pick and any future users agree on it.
package uart_tx_arb_pkg;

    localparam int WORD_W  = 32;
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RECOVER
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of valid, searching upward from ptr+1 and wrapping at num_req.
    function automatic pick_t rr_pick_fn(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
        pick_t result;
        int    cand;
        result = '0;
        for (int step = 1; step <= MAX_REQ; step++) begin
            cand = int'(ptr) + step;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((step <= num_req) && !result.found && valid[cand[2:0]]) begin
                result.found = 1'b1;
                result.idx   = cand[2:0];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: picks the next valid requester after ptr.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         ptr_ext;
    pick_t              pick;

    assign valid_ext = MAX_REQ'(valid);
    assign ptr_ext   = 3'(ptr);
    assign pick      = rr_pick_fn(valid_ext, ptr_ext, NUM_REQ);
    assign idx       = IDX_W'(pick.idx);
    assign found     = pick.found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 32-bit-frame uart_tx among NUM_REQ requesters.
// Optional frame watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CLKS_PER_BIT   = 87,
    parameter int TIMEOUT_CYCLES = CLKS_PER_BIT * 36
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic [NUM_REQ-1:0]          i_Req_Valid,
    input  logic [NUM_REQ*WORD_W-1:0]   i_Req_Data,
    output logic [NUM_REQ-1:0]          o_Req_Ack,
    output logic                        o_Tx_DV,
    output logic [WORD_W-1:0]           o_Tx_Byte,
    input  logic                        i_Tx_Active,
    input  logic                        i_Tx_Done,
    output logic [$clog2(NUM_REQ)-1:0]  o_Grant_Idx,
    output logic                        o_Busy,
    output logic                        o_Timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic [IDX_W-1:0]   grant_next;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] ack_next;
    logic               dv_next;
    logic [WORD_W-1:0]  byte_next;
    logic               timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid (i_Req_Valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_count;

    assign timeout_hit = (wd_count == CNT_W'(TIMEOUT_CYCLES));

    // Cleared on the way into WAIT_BUSY; saturates so an expiry seen in RECOVER releases at once.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wd_count  <= '0;
            o_Timeout <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_count <= '0;
            end else if ((state != IDLE) && !timeout_hit) begin
                wd_count <= wd_count + 1'b1;
            end
            if (timeout_hit && ((state == WAIT_BUSY) || (state == WAIT_DONE))) begin
                o_Timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_Timeout   = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        grant_next  = o_Grant_Idx;
        ack_next    = '0;
        dv_next     = 1'b0;
        byte_next   = o_Tx_Byte;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next           = ISSUE;
                    rr_ptr_next          = pick_idx;
                    grant_next           = pick_idx;
                    ack_next[pick_idx]   = 1'b1;
                    byte_next            = i_Req_Data[pick_idx*WORD_W +: WORD_W];
                end
            end
            ISSUE: begin
                dv_next    = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timeout_hit) begin
                    state_next = RECOVER;
                end else if (i_Tx_Active) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout_hit || i_Tx_Done) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                // Done stays high for two cycles; only a fully quiet transmitter releases us.
                if (timeout_hit || (!i_Tx_Active && !i_Tx_Done)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = RECOVER;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= RECOVER;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            o_Grant_Idx <= '0;
            o_Req_Ack   <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= '0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            o_Grant_Idx <= grant_next;
            o_Req_Ack   <= ack_next;
            o_Tx_DV     <= dv_next;
            o_Tx_Byte   <= byte_next;
        end
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx instance (32-bit word frames: start bit, 32 data bits LSB first, stop bit) among NUM_REQ requesters.
- Accepts one 32-bit word per grant, holds it stable on the transmitter's data input, pulses the transmitter's data-valid strobe, and tracks Active/Done until the frame completes.
- Sits between the bus-side producers (CPU, debug/trace sources) and the uart_tx instance.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- CLKS_PER_BIT, 87: must equal the value given to the attached uart_tx; used only for the timeout bound.
- TIMEOUT_CYCLES, CLKS_PER_BIT*36: watchdog limit per frame (optional feature only).

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req_Valid  in  NUM_REQ  per-requester word available.
- i_Req_Data  in  NUM_REQ*32  requester k data at bits [32k+31:32k].
- o_Req_Ack  out  NUM_REQ  one-cycle pulse: requester k's word captured; requester may then change data or drop valid.
- o_Tx_DV  out  1  to uart_tx i_Tx_DV.
- o_Tx_Byte  out  32  to uart_tx i_Tx_Byte; held stable from capture until the frame completes.
- i_Tx_Active  in  1  from uart_tx o_Tx_Active.
- i_Tx_Done  in  1  from uart_tx o_Tx_Done.
- o_Grant_Idx  out  $clog2(NUM_REQ)  index of the requester currently owning the line.
- o_Busy  out  1  high in every state except IDLE.
- o_Timeout  out  1  sticky error flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset values: o_Req_Ack=0, o_Tx_DV=0, o_Tx_Byte=0, o_Grant_Idx=0, o_Timeout=0, rr_ptr=NUM_REQ-1, state=RECOVER (so o_Busy=1).
- uart_tx has no reset, so after reset the block must not issue until the transmitter is quiet.
- States:
  - IDLE: if any valid, pick the first set bit searching from rr_ptr+1 modulo NUM_REQ. Capture its data into o_Tx_Byte, pulse its ack, set o_Grant_Idx and rr_ptr to that index, go to ISSUE. No valid: stay.
  - ISSUE: o_Tx_DV=1 for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: on i_Tx_Active=1 go to WAIT_DONE.
  - WAIT_DONE: on i_Tx_Done=1 go to RECOVER.
  - RECOVER: when i_Tx_Active=0 and i_Tx_Done=0 in the same cycle, go to IDLE. The Done pulse lasts 2 cycles; this state absorbs it so one frame is never counted twice.
- Latency:
  - Valid to ack: 1 cycle when IDLE.
  - Ack to DV: 1 cycle.
  - Back-to-back frames: at least 3 idle clocks between frames, from Done high to the next DV.
- Only one ack per grant. A requester that keeps valid high after its ack is re-offered next round. With other requesters pending, fairness guarantees it waits at most NUM_REQ-1 frames.
- Valid may drop without ack; the arbiter never captures it then (no requirement to hold).
- Requests arriving in non-IDLE states wait; they are not latched.
- o_Tx_Byte is loaded only in IDLE on grant.
- Reset mid-frame: all outputs return to reset values immediately. The frame in flight finishes on the wire; the block stays in RECOVER until the transmitter idles.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined: a counter clears on entering WAIT_BUSY and runs in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES, set o_Timeout=1 (cleared only by reset) and go to RECOVER. The counter also runs in RECOVER; on expiry there the block goes to IDLE regardless of transmitter inputs.
- Undefined: no counter; o_Timeout tied 0; the states wait indefinitely.

Decomposition:
- Package uart_tx_arb_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RECOVER), WORD_W=32 constant, and a function computing the rotating-priority pick (valid vector, pointer -> index, found).
- One sub-module: rr_pick, the combinational rotating-priority encoder, so the bench can test it standalone.

Test Plan:
- Single requester: req0 valid, data 32'hDEADBEEF -> ack0 on the next cycle, DV one cycle later. Serial line decodes DEADBEEF LSB first; o_Busy low 3+ cycles after Done.
- Round robin: all 4 valid continuously, each with distinct data -> grant order 0,1,2,3,0,1. Exactly one ack per frame.
- Pointer wrap: rr_ptr=3, only req1 and req3 valid -> req1 granted first, then req3.
- Reset mid-frame: assert i_Rst_n low during data bit 10 of frame 1 -> outputs reset. No DV until uart_tx Active and Done are both 0; the next frame is clean.
- Done pulse width: Done held 2 cycles -> exactly one frame credited; no spurious second DV.
- UART_TX_ARB_TIMEOUT_EN: stub transmitter never raises Active -> o_Timeout=1 after TIMEOUT_CYCLES, block returns to IDLE, and the next request is granted.
